// File: rtl/rgb_ycc_pkg.sv
// rtl/rgb_ycc_pkg.sv - mode/FSM enums and 8-bit-fraction conversion coefficients
package rgb_ycc_pkg;

  typedef enum logic [1:0] {
    MODE_RGB   = 2'd0,
    MODE_YPBPR = 2'd1,
    MODE_YCBCR = 2'd2
  } mode_e;

  typedef enum logic {
    STEADY  = 1'b0,
    PENDING = 1'b1
  } fsm_state_e;

  // Rows are output channels: 0 = G/Y, 1 = B/Pb/Cb, 2 = R/Pr/Cr. Columns are inputs R, G, B.
  // Passthrough uses unity gain (256 = 1.0) so it rides the same pipe as the converters.
  localparam int COEF_PASS  [3][3] = '{'{  0, 256,   0}, '{  0,   0, 256}, '{256,    0,   0}};
  localparam int COEF_YPBPR [3][3] = '{'{ 77, 150,  29}, '{-43, -85, 128}, '{128, -107, -21}};
  localparam int COEF_YCBCR [3][3] = '{'{ 66, 129,  25}, '{-38, -74, 112}, '{112,  -94, -18}};

  // Black level of limited-range Y, in 8-bit units.
  localparam int Y_OFFSET_8 = 16;

  // Coefficient at 8 fraction bits; mode 3 falls through to passthrough.
  function automatic int coef8(logic [1:0] mode, int row, int col);
    case (mode)
      MODE_YPBPR: return COEF_YPBPR[row][col];
      MODE_YCBCR: return COEF_YCBCR[row][col];
      default:    return COEF_PASS[row][col];
    endcase
  endfunction

endpackage

// File: rtl/ycc_channel_mac.sv
// rtl/ycc_channel_mac.sv - one output channel: multiply, sum+offset+round, clamp
module ycc_channel_mac #(
  parameter int WIDTH  = 8,
  parameter int COEF_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic signed [COEF_W+1:0] coef_r_i,
  input  logic signed [COEF_W+1:0] coef_g_i,
  input  logic signed [COEF_W+1:0] coef_b_i,
  input  logic        [WIDTH:0]    offset_i,
  input  logic        [WIDTH-1:0]  red_i,
  input  logic        [WIDTH-1:0]  green_i,
  input  logic        [WIDTH-1:0]  blue_i,
  output logic        [WIDTH-1:0]  data_o
);

  localparam int SW = WIDTH + COEF_W + 2;
  localparam logic signed [SW-1:0] ROUND = SW'(2 ** (COEF_W - 1));

  logic signed [SW-1:0] prod_r_q, prod_g_q, prod_b_q;
  logic        [WIDTH:0] offset_q;
  logic signed [SW-1:0] sum_q;
  logic        [WIDTH-1:0] data_q;
  logic signed [SW-1:0] offset_scaled;
  logic signed [SW-1:0] shifted;
  logic        [WIDTH-1:0] clamp_d;

  function automatic logic signed [SW-1:0] ext_pix(logic [WIDTH-1:0] p);
    return $signed({{(SW - WIDTH){1'b0}}, p});
  endfunction

  function automatic logic signed [SW-1:0] ext_coef(logic signed [COEF_W+1:0] c);
    return $signed({{(SW - COEF_W - 2){c[COEF_W+1]}}, c});
  endfunction

  assign offset_scaled = $signed({{(COEF_W + 1){1'b0}}, offset_q}) <<< COEF_W;
  assign shifted       = sum_q >>> COEF_W;

  // Saturate the integer part to the unsigned output range.
  always_comb begin
    clamp_d = shifted[WIDTH-1:0];
    if (shifted[SW-1]) begin
      clamp_d = '0;
    end else if (|shifted[SW-2:WIDTH]) begin
      clamp_d = '1;
    end
  end

  // Three ce-qualified stages; offset travels with its products.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      offset_q <= '0;
      sum_q    <= '0;
      data_q   <= '0;
    end else if (ce) begin
      prod_r_q <= ext_pix(red_i)   * ext_coef(coef_r_i);
      prod_g_q <= ext_pix(green_i) * ext_coef(coef_g_i);
      prod_b_q <= ext_pix(blue_i)  * ext_coef(coef_b_i);
      offset_q <= offset_i;
      sum_q    <= prod_r_q + prod_g_q + prod_b_q + offset_scaled + ROUND;
      data_q   <= clamp_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/rgb_ycc_convert_pipe.sv
// rtl/rgb_ycc_convert_pipe.sv - frame-switched RGB to YPbPr/YCbCr pipe with aligned syncs
module rgb_ycc_convert_pipe #(
  parameter int WIDTH        = 8,
  parameter int COEF_W       = 8,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] red_in,
  input  logic [WIDTH-1:0] green_in,
  input  logic [WIDTH-1:0] blue_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             cs_in,
  input  logic             pixel_in,
  output logic [WIDTH-1:0] red_out,
  output logic [WIDTH-1:0] green_out,
  output logic [WIDTH-1:0] blue_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             cs_out,
  output logic             pixel_out,
  output logic [1:0]       mode_out
);

  import rgb_ycc_pkg::*;

  localparam int CW = COEF_W + 2;
  localparam logic [1:0]   DEF_MODE = DEFAULT_MODE[1:0];
  localparam logic [WIDTH:0] HALF   = (WIDTH + 1)'(1) << (WIDTH - 1);
  localparam logic [WIDTH:0] Y_OFF  = (WIDTH + 1)'(Y_OFFSET_8) << (WIDTH - 8);

  fsm_state_e state_q;
  logic [1:0] active_q, pending_q;
  logic       vs_prev_q;
  logic       vs_rise;
  logic [1:0] mode_d;
  logic [1:0] mode_s1_q, mode_s2_q, mode_s3_q;
  logic [3:0] sync_s1_q, sync_s2_q, sync_s3_q;
  logic [WIDTH-1:0] ch_data [3];

  function automatic logic signed [CW-1:0] coef_scaled(logic [1:0] m, int row, int col);
    return CW'(coef8(m, row, col) * (2 ** (COEF_W - 8)));
  endfunction

  function automatic logic [WIDTH:0] offset_of(logic [1:0] m, int row);
    if (m == MODE_YPBPR) return (row == 0) ? '0 : HALF;
    if (m == MODE_YCBCR) return (row == 0) ? Y_OFF : HALF;
    return '0;
  endfunction

  // The pixel arriving on the switching vsync edge already uses the new mode.
  assign vs_rise = vs_in & ~vs_prev_q;
  assign mode_d  = (state_q == PENDING && vs_rise) ? pending_q : active_q;

  // Mode request FSM: latch the latest request, apply it only on a vsync rise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= STEADY;
      active_q  <= DEF_MODE;
      pending_q <= DEF_MODE;
      vs_prev_q <= 1'b0;
    end else if (ce) begin
      vs_prev_q <= vs_in;
      case (state_q)
        STEADY: begin
          if (mode_in != active_q) begin
            pending_q <= mode_in;
            state_q   <= PENDING;
          end
        end
        PENDING: begin
          if (vs_rise) begin
            active_q <= pending_q;
            state_q  <= STEADY;
          end else if (mode_in == active_q) begin
            state_q <= STEADY;
          end else begin
            pending_q <= mode_in;
          end
        end
        default: state_q <= STEADY;
      endcase
    end
  end

  // Mode tag and syncs ride alongside the data stages so nothing slips.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_s1_q <= DEF_MODE;
      mode_s2_q <= DEF_MODE;
      mode_s3_q <= DEF_MODE;
      sync_s1_q <= '0;
      sync_s2_q <= '0;
      sync_s3_q <= '0;
    end else if (ce) begin
      mode_s1_q <= mode_d;
      mode_s2_q <= mode_s1_q;
      mode_s3_q <= mode_s2_q;
      sync_s1_q <= {hs_in, vs_in, cs_in, pixel_in};
      sync_s2_q <= sync_s1_q;
      sync_s3_q <= sync_s2_q;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    ycc_channel_mac #(.WIDTH(WIDTH), .COEF_W(COEF_W)) u_mac (
      .clk      (clk),
      .reset_n  (reset_n),
      .ce       (ce),
      .coef_r_i (coef_scaled(mode_d, ch, 0)),
      .coef_g_i (coef_scaled(mode_d, ch, 1)),
      .coef_b_i (coef_scaled(mode_d, ch, 2)),
      .offset_i (offset_of(mode_d, ch)),
      .red_i    (red_in),
      .green_i  (green_in),
      .blue_i   (blue_in),
      .data_o   (ch_data[ch])
    );
  end

  assign green_out = ch_data[0];
  assign blue_out  = ch_data[1];
  assign red_out   = ch_data[2];
  assign {hs_out, vs_out, cs_out, pixel_out} = sync_s3_q;
  assign mode_out  = mode_s3_q;

endmodule

// File: tb/tb_rgb_ycc_convert_pipe.sv
// tb/tb_rgb_ycc_convert_pipe.sv - scoreboard bench for the colour-space converter
module tb_rgb_ycc_convert_pipe;

  localparam logic [1:0] DEF = 2'd0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic [1:0] mode_in = 2'd0;
  logic [7:0] red_in = '0, green_in = '0, blue_in = '0;
  logic       hs_in = 0, vs_in = 0, cs_in = 0, pixel_in = 0;
  logic [7:0] red_out, green_out, blue_out;
  logic       hs_out, vs_out, cs_out, pixel_out;
  logic [1:0] mode_out;

  typedef struct packed {
    logic [1:0] mode;
    logic hs, vs, cs, px;
    logic [7:0] r, g, b;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp = '0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [1:0] m_active = DEF;
  logic [1:0] m_prev_req = DEF;
  logic       m_prev_vs = 1'b0;
  logic       ce_edge = 1'b0;
  logic       rst_edge = 1'b0;

  rgb_ycc_convert_pipe #(.WIDTH(8), .COEF_W(8), .DEFAULT_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .mode_in(mode_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hs_in(hs_in), .vs_in(vs_in), .cs_in(cs_in), .pixel_in(pixel_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hs_out(hs_out), .vs_out(vs_out), .cs_out(cs_out), .pixel_out(pixel_out),
    .mode_out(mode_out)
  );

  always #5 clk = ~clk;

  // Fixed-point value with 8 fraction bits and the half-LSB already added, to a clamped 8-bit pixel.
  function automatic logic [7:0] to_px(int acc);
    int v;
    if (acc < 0) return 8'd0;
    v = acc / 256;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic exp_t model(logic [7:0] r, g, b, logic hs, vs, cs, px, logic [1:0] m);
    exp_t e;
    int ri, gi, bi;
    ri = r; gi = g; bi = b;
    e.mode = m; e.hs = hs; e.vs = vs; e.cs = cs; e.px = px;
    case (m)
      2'd1: begin
        e.g = to_px(77*ri + 150*gi + 29*bi + 128);
        e.b = to_px(-43*ri - 85*gi + 128*bi + 128*256 + 128);
        e.r = to_px(128*ri - 107*gi - 21*bi + 128*256 + 128);
      end
      2'd2: begin
        e.g = to_px(66*ri + 129*gi + 25*bi + 16*256 + 128);
        e.b = to_px(-38*ri - 74*gi + 112*bi + 128*256 + 128);
        e.r = to_px(112*ri - 94*gi - 18*bi + 128*256 + 128);
      end
      default: begin
        e.r = r; e.g = g; e.b = b;
      end
    endcase
    return e;
  endfunction

  // One input cycle; on an accepted pixel the expected output is queued.
  task automatic step_fix(input bit c, input logic [7:0] r, g, b, input logic hs, vs, cs, px,
                          input logic [1:0] req, input bit fix, input logic [7:0] fy, fb, fr);
    exp_t e;
    ce = c; red_in = r; green_in = g; blue_in = b;
    hs_in = hs; vs_in = vs; cs_in = cs; pixel_in = px; mode_in = req;
    if (c && reset_n) begin
      if (vs && !m_prev_vs) m_active = m_prev_req;
      m_prev_req = req;
      m_prev_vs  = vs;
      e = model(r, g, b, hs, vs, cs, px, m_active);
      if (fix) begin
        e.g = fy; e.b = fb; e.r = fr;
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit c, input logic [7:0] r, g, b, input logic hs, vs, cs, px,
                      input logic [1:0] req);
    step_fix(c, r, g, b, hs, vs, cs, px, req, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic do_reset(input int cycles);
    exp_t z;
    reset_n = 1'b0;
    for (int i = 0; i < cycles; i++)
      step(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)));
    m_active = DEF; m_prev_req = DEF; m_prev_vs = 1'b0;
    sb_q.delete();
    z = '0; z.mode = DEF;
    sb_q.push_back(z);
    sb_q.push_back(z);
    reset_n = 1'b1;
  endtask

  task automatic chk(input string name, input exp_t want);
    exp_t got;
    got = {mode_out, hs_out, vs_out, cs_out, pixel_out, red_out, green_out, blue_out};
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got mode=%0d hs/vs/cs/px=%b%b%b%b r=%0d g=%0d b=%0d, want mode=%0d hs/vs/cs/px=%b%b%b%b r=%0d g=%0d b=%0d",
                  name, got.mode, got.hs, got.vs, got.cs, got.px, got.r, got.g, got.b,
                  want.mode, want.hs, want.vs, want.cs, want.px, want.r, want.g, want.b);
  endtask

  always @(posedge clk) begin
    ce_edge  <= ce && reset_n;
    rst_edge <= !reset_n;
  end

  // Monitor: compare each advanced output against the queue, and held outputs against the last one.
  always @(negedge clk) begin
    exp_t z;
    if (rst_edge) begin
      z = '0; z.mode = DEF;
      chk("reset", z);
      last_exp = z;
    end else if (ce_edge) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty: output advanced with no expected entry");
      end else begin
        z = sb_q.pop_front();
        chk("pipe", z);
        last_exp = z;
      end
    end else begin
      chk("hold", last_exp);
    end
  end

  initial begin
    bit         c;
    logic       vs_lvl;
    logic [1:0] req;
    bit         pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    do_reset(5);

    // Passthrough, then a mid-line request for mode 1 that waits for vsync.
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), 8'($urandom), 8'($urandom), 1, 0, 1, 1, 2'd0);
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 1, 2'd1);
    step_fix(1, 8'd255, 8'd255, 8'd255, 0, 1, 0, 1, 2'd1, 1'b1, 8'd255, 8'd128, 8'd128);
    step_fix(1, 8'd0, 8'd0, 8'd0, 0, 1, 0, 1, 2'd1, 1'b1, 8'd0, 8'd128, 8'd128);
    step(1, 8'd255, 8'd0, 8'd0, 0, 1, 0, 1, 2'd1);
    step(1, 8'd0, 8'd255, 8'd0, 0, 1, 0, 1, 2'd1);

    // Switch to limited-range YCbCr.
    for (int i = 0; i < 2; i++) step(1, 8'($urandom), 8'($urandom), 8'($urandom), 1, 0, 1, 0, 2'd2);
    step_fix(1, 8'd255, 8'd255, 8'd255, 0, 1, 0, 1, 2'd2, 1'b1, 8'd235, 8'd128, 8'd128);
    step_fix(1, 8'd0, 8'd0, 8'd0, 0, 1, 0, 1, 2'd2, 1'b1, 8'd16, 8'd128, 8'd128);
    step(1, 8'd0, 8'd0, 8'd255, 0, 1, 0, 1, 2'd2);

    // Back to passthrough, then a 0->1->0 request before the edge must not switch.
    step(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 1, 2'd0);
    step(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 0, 1, 2'd0);
    step(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 1, 2'd0);
    step(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 1, 2'd1);
    step(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 1, 2'd0);
    step(1, 8'd200, 8'd100, 8'd50, 0, 1, 0, 1, 2'd0);
    step(1, 8'd10, 8'd20, 8'd30, 0, 1, 0, 1, 2'd0);

    // ce pattern 1,0,0,1 with syncs toggling.
    for (int k = 0; k < 12; k++)
      step(pat[k % 4], 8'($urandom), 8'($urandom), 8'($urandom), 1'(k), 1'(k >> 2), 1'(~k), 1'(k >> 1), 2'd0);

    // Randomised frames with occasional mode requests and a mid-run reset.
    vs_lvl = 1'b0;
    req = 2'd0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 700; i++) begin
        c = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 29) == 0) vs_lvl = ~vs_lvl;
        if ($urandom_range(0, 24) == 0) req = 2'($urandom_range(0, 2));
        if (c && vs_lvl && !m_prev_vs) req = m_prev_req;
        step(c, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), vs_lvl, 1'($urandom),
             1'($urandom), req);
      end
      if (pass == 0) begin
        do_reset(3);
        vs_lvl = 1'b0;
        req = DEF;
      end
    end

    for (int i = 0; i < 4; i++) step(1, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0, req);
    ce = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
